// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1 UART receiver: two-flop pin synchroniser, glitch-rejecting start
// detection, mid-bit sampling, holding register with valid/ready, framing/overrun pulses.
module uart_rx_oversample #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int SCNT_W = $clog2(OVERSAMPLE * 10 + 1);
  localparam int HALF   = OVERSAMPLE / 2;
  localparam logic [SCNT_W-1:0] START_TICK = SCNT_W'(HALF);
  localparam logic [SCNT_W-1:0] STOP_TICK  = SCNT_W'(HALF + 9 * OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state_q;
  logic               sync_q, rxs_q, rxs_prev_q;
  logic [DIV_W-1:0]   tcnt_q;
  logic [SCNT_W-1:0]  scnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic [7:0]         rx_data_q;
  logic               rx_valid_q, frame_err_q, overrun_q, busy_q;
  logic               deliver_q, ferr_pend_q;

  logic               fall;
  logic               tick;
  logic [SCNT_W-1:0]  tick_num;
  logic [SCNT_W-1:0]  data_tick;

  assign fall      = !rxs_q && rxs_prev_q;
  assign tick      = (tcnt_q == '0);
  assign tick_num  = scnt_q + 1'b1;
  assign data_tick = SCNT_W'(HALF + OVERSAMPLE * (int'(bit_q) + 1));

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      tcnt_q      <= '0;
      scnt_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      deliver_q   <= 1'b0;
      ferr_pend_q <= 1'b0;
    end else begin
      sync_q      <= rx;
      rxs_q       <= sync_q;
      rxs_prev_q  <= rxs_q;
      deliver_q   <= 1'b0;
      ferr_pend_q <= 1'b0;
      frame_err_q <= ferr_pend_q;
      overrun_q   <= 1'b0;

      // Stop-bit decisions are staged one clk so the outputs land a cycle after the stop tick.
      if (deliver_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q  <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if (state_q == S_IDLE) begin
        tcnt_q <= clk_div;
        if (fall) begin
          state_q <= S_START;
          scnt_q  <= '0;
          bit_q   <= '0;
          busy_q  <= 1'b1;
        end
      end else begin
        if (tick) begin
          tcnt_q <= clk_div;
          scnt_q <= tick_num;
        end else begin
          tcnt_q <= tcnt_q - 1'b1;
        end

        case (state_q)
          S_START: begin
            if (tick && tick_num == START_TICK) begin
              if (rxs_q) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (tick && tick_num == data_tick) begin
              shift_q <= {rxs_q, shift_q[7:1]};
              bit_q   <= bit_q + 1'b1;
              if (bit_q == 3'd7) state_q <= S_STOP;
            end
          end
          S_STOP: begin
            if (tick && tick_num == STOP_TICK) begin
              if (rxs_q) begin
                deliver_q <= 1'b1;
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
              end else begin
                ferr_pend_q <= 1'b1;
                state_q     <= S_BREAK;
              end
            end
          end
          S_BREAK: begin
            // Wait for the line to recover so a held-low break cannot retrigger a frame.
            if (rxs_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
